usadd_frame_ctrl: RTL and testbench
===================================

// Module: usadd_frame_ctrl
// PURPOSE
//  Frame sequencer for the 16-input unary scaled adder (uSADD) datapath.
//  Accepts a start command with a frame length, clears the adder residue, enables
//  the bitstream sources and the adder for exactly that many cycles, and counts
//  adder output 1s. Returns the binary count via a valid/ready result handshake.
//  Sits between the host/command logic and one uSADD instance plus its stream sources.
// PARAMETERS
//  CNT_W   8  frame-length counter width; max frame = 2**CNT_W cycles
// PORTS
//  iClk         in   1        clock, all logic on rising edge
//  iRstN        in   1        synchronous reset, active low
//  iStartValid  in   1        start command valid
//  oStartReady  out  1        start command accepted when high (IDLE only)
//  iFrameLen    in   CNT_W    frame length in cycles; 0 encodes 2**CNT_W
//  oSaddClr     out  1        1-cycle clear pulse to uSADD residue register
//  oSaddEn      out  1        uSADD accumulate enable (residue holds when low)
//  oSrcEn       out  1        bitstream source enable, equal to oSaddEn
//  iSaddOut     in   1        uSADD output bit, same-cycle combinational result
//  oResValid    out  1        result valid
//  iResReady    in   1        result consumer ready
//  oResult      out  CNT_W+1  number of 1s seen on iSaddOut during the frame
//  oBusy        out  1        high in any state other than IDLE
// BEHAVIOUR
//  - Reset (iRstN low at edge): state IDLE, counters 0, oResult 0; all outputs 0
//    except oStartReady=1. Reset has priority at every state, including mid-frame.
//  - FSM states IDLE, CLEAR, RUN, DONE; all outputs decoded from registered state.
//  - IDLE: oStartReady=1. Start accepted on iStartValid&oStartReady; latch
//    iFrameLen into remaining counter (0 -> 2**CNT_W, counter CNT_W+1 bits wide),
//    zero the ones counter, go CLEAR.
//  - CLEAR: oSaddClr=1 for exactly one cycle; go RUN.
//  - RUN: oSaddEn=oSrcEn=1. Each cycle: ones += iSaddOut; remaining -= 1.
//    When remaining==1 at the edge, go DONE. RUN lasts exactly frame-length cycles.
//  - DONE: oResValid=1, oResult stable and held until accepted.
//    iResReady high -> IDLE on that edge (ready may already be high on entry).
//  - Latency: start accepted at edge t -> CLEAR in cycle t+1, RUN in cycles
//    t+2..t+1+L, oResValid from cycle t+2+L. Min start-to-start spacing L+3 cycles.
//  - iStartValid outside IDLE is ignored (not queued). iFrameLen sampled only at accept.
//  - No overflow: ones <= L <= 2**CNT_W fits in CNT_W+1 bits.
//  - iSaddOut is ignored outside RUN.
// CONFIGURATION
//  USADD_CTRL_ABORT_EN defined: adds input iAbort (1 bit) and output oAborted (1 bit).
//   iAbort high in CLEAR or RUN -> IDLE next edge, no result produced, oResult
//   keeps previous value, oAborted pulses 1 cycle (in first IDLE cycle).
//   iAbort in IDLE or DONE is ignored. Reset still has priority over iAbort.
//  Not defined: ports absent; every accepted frame runs to DONE.
// TESTING
//  1. Reset then start L=4, iSaddOut=1,0,1,1 -> oSaddClr 1 cycle, oSaddEn 4 cycles,
//     oResValid with oResult=3, held 5 cycles with iResReady=0, then IDLE on ready.
//  2. iFrameLen=0, CNT_W=8, iSaddOut=1 constant -> RUN 256 cycles, oResult=256.
//  3. iStartValid held high in RUN/DONE with different iFrameLen -> ignored;
//     result matches first length; next start accepted only after return to IDLE.
//  4. iRstN low mid-RUN (cycle 3 of L=10) -> next cycle IDLE, oSaddEn=0,
//     oResult=0, oStartReady=1; new frame L=2 gives correct count.
//  5. iResReady high before DONE, L=1, iSaddOut=1 -> oResValid for 1 cycle,
//     oResult=1, back-to-back start accepted in following IDLE cycle.
//  6. (USADD_CTRL_ABORT_EN) iAbort in RUN cycle 2 of L=8 -> IDLE, oAborted 1-cycle
//     pulse, oResValid never asserted, oResult unchanged.

Source files
------------

// File: rtl/usadd_frame_ctrl.sv
// Purpose : frame sequencer for one 16-input uSADD; clears residue, runs L cycles, counts output 1s.
// Latency : start accepted at edge t -> CLEAR t+1, RUN t+2..t+1+L, oResValid from t+2+L.
// Backpr. : start taken only in IDLE (not queued); result held in DONE until iResReady.
//
// Optional feature macro: USADD_CTRL_ABORT_EN (adds iAbort / oAborted).
//
// Ports:
//   iClk, iRstN          clock, synchronous active-low reset
//   iStartValid/oStartReady, iFrameLen   start command (frame length, 0 = 2**CNT_W)
//   oSaddClr             one-cycle residue clear to the adder
//   oSaddEn, oSrcEn      adder accumulate enable / stream source enable (identical)
//   iSaddOut             adder output bit, counted only while running
//   oResValid/iResReady, oResult   result handshake, count of 1s (CNT_W+1 bits)
//   oBusy                high whenever not idle
//   iAbort, oAborted     (macro only) cancel a frame in CLEAR/RUN, one-cycle abort flag
module usadd_frame_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStartValid,
  output logic             oStartReady,
  input  logic [CNT_W-1:0] iFrameLen,
  output logic             oSaddClr,
  output logic             oSaddEn,
  output logic             oSrcEn,
  input  logic             iSaddOut,
  output logic             oResValid,
  input  logic             iResReady,
  output logic [CNT_W:0]   oResult,
  output logic             oBusy
`ifdef USADD_CTRL_ABORT_EN
  ,
  input  logic             iAbort,
  output logic             oAborted
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A zero length field encodes the full 2**CNT_W frame, hence the extra counter bit.
  localparam logic [CNT_W:0] FULL_LEN = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE      = {{CNT_W{1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [CNT_W:0] rem_q, rem_d;
  logic [CNT_W:0] ones_q, ones_d;
  logic [CNT_W:0] result_q, result_d;
  logic           abort_w;

`ifdef USADD_CTRL_ABORT_EN
  assign abort_w = iAbort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ones_d   = ones_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (iStartValid) begin
          rem_d   = (iFrameLen == '0) ? FULL_LEN : {1'b0, iFrameLen};
          ones_d  = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = abort_w ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort_w) begin
          state_d = ST_IDLE;
        end else begin
          ones_d = ones_q + {{CNT_W{1'b0}}, iSaddOut};
          rem_d  = rem_q - ONE;
          // Last run cycle: the final adder bit is folded into the captured result,
          // so oResult only changes on entry to DONE and survives aborts untouched.
          if (rem_q == ONE) begin
            result_d = ones_d;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (iResReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef USADD_CTRL_ABORT_EN
  logic aborted_q, aborted_d;

  always_comb begin
    aborted_d = abort_w && ((state_q == ST_CLEAR) || (state_q == ST_RUN));
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end

  assign oAborted = aborted_q;
`endif

  assign oStartReady = (state_q == ST_IDLE);
  assign oSaddClr    = (state_q == ST_CLEAR);
  assign oSaddEn     = (state_q == ST_RUN);
  assign oSrcEn      = (state_q == ST_RUN);
  assign oResValid   = (state_q == ST_DONE);
  assign oBusy       = (state_q != ST_IDLE);
  assign oResult     = result_q;

endmodule

// File: tb/tb_usadd_frame_ctrl.sv
// Purpose : self-checking bench for usadd_frame_ctrl with a frame-level reference model.
// Latency : inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
// Backpr. : result ready driven both directed and randomly.
module tb_usadd_frame_ctrl;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start_vld = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             sadd = 1'b0;
  logic             ready = 1'b0;
  logic             start_rdy, clr, en, src_en, res_vld, busy;
  logic [CNT_W:0]   result;
  logic             abort_in;
`ifdef USADD_CTRL_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  always #5 clk = ~clk;

  usadd_frame_ctrl #(.CNT_W(CNT_W)) dut (
    .iClk(clk), .iRstN(rstn),
    .iStartValid(start_vld), .oStartReady(start_rdy), .iFrameLen(len),
    .oSaddClr(clr), .oSaddEn(en), .oSrcEn(src_en), .iSaddOut(sadd),
    .oResValid(res_vld), .iResReady(ready), .oResult(result), .oBusy(busy)
`ifdef USADD_CTRL_ABORT_EN
    , .iAbort(abort), .oAborted(aborted)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is described by its age (cycles since acceptance),
  // its length and the running count of 1s; outputs follow from age versus length.
  bit m_known = 1'b0;
  bit m_idle = 1'b1;
  int m_off = 0;
  int m_len = 0;
  int m_ones = 0;
  int m_result = 0;
  bit m_aborted = 1'b0;
  bit e_clr, e_en, e_vld;

  always @(negedge clk) begin
    e_clr = !m_idle && (m_off == 1);
    e_en  = !m_idle && (m_off >= 2) && (m_off <= m_len + 1);
    e_vld = !m_idle && (m_off >= m_len + 2);
    if (m_known) begin
      check("start_ready", start_rdy, m_idle);
      check("sadd_clr", clr, e_clr);
      check("sadd_en", en, e_en);
      check("src_en", src_en, e_en);
      check("res_valid", res_vld, e_vld);
      check("busy", busy, !m_idle);
      check("result", result, m_result);
`ifdef USADD_CTRL_ABORT_EN
      check("aborted", aborted, m_aborted);
`endif
    end
    // advance the model across the coming rising edge
    if (!rstn) begin
      m_known = 1'b1; m_idle = 1'b1; m_result = 0; m_aborted = 1'b0;
    end else if (m_known) begin
      m_aborted = 1'b0;
      if (m_idle) begin
        if (start_vld) begin
          m_idle = 1'b0; m_off = 1; m_ones = 0;
          m_len = (len == 0) ? (1 << CNT_W) : int'(len);
        end
      end else if (abort_in && (e_clr || e_en)) begin
        m_idle = 1'b1; m_aborted = 1'b1;
      end else if (e_vld) begin
        if (ready) m_idle = 1'b1;
      end else begin
        if (e_en) m_ones += int'(sadd);
        m_off++;
        if (m_off == m_len + 2) m_result = m_ones;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int l);
    start_vld = 1'b1;
    len = l[CNT_W-1:0];
    tick();
    start_vld = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (res_vld !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("wait_valid", res_vld, 1);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  logic [3:0] pat;

  initial begin
    tick(); tick();
    rstn = 1'b1;
    check("reset_ready", start_rdy, 1);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);

    // 1: L=4, adder bits 1,0,1,1 -> 3, held while ready low
    pat = 4'b1101;
    start(4);
    check("t1_clr", clr, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_en", en, 1);
      sadd = pat[i];
      tick();
    end
    sadd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t1_valid_held", res_vld, 1);
      check("t1_result", result, 3);
      tick();
    end
    accept();
    check("t1_idle", start_rdy, 1);

    // 2: length 0 encodes the full 256-cycle frame
    sadd = 1'b1;
    start(0);
    wait_valid(300);
    check("t2_result", result, 256);
    accept();

    // 3: start held high with changing length while busy is ignored
    start_vld = 1'b1; len = 8'd5;
    tick();
    for (int i = 0; i < 20 && res_vld !== 1'b1; i++) begin
      len = CNT_W'($urandom_range(6, 15));
      tick();
    end
    check("t3_valid", res_vld, 1);
    check("t3_result", result, 5);
    check("t3_not_ready", start_rdy, 0);
    len = 8'd2; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_idle", start_rdy, 1);
    tick();
    start_vld = 1'b0;
    check("t3_restart_clr", clr, 1);
    wait_valid(10);
    check("t3_result2", result, 2);
    accept();

    // 4: reset in cycle 3 of an L=10 run
    start(10);
    tick(); tick(); tick();
    check("t4_in_run", en, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t4_en_off", en, 0);
    check("t4_result0", result, 0);
    check("t4_ready", start_rdy, 1);
    start(2);
    wait_valid(10);
    check("t4_result", result, 2);
    accept();

    // 5: ready already high, L=1, back-to-back start
    ready = 1'b1;
    start(1);
    tick();
    tick();
    check("t5_valid", res_vld, 1);
    check("t5_result", result, 1);
    start_vld = 1'b1; len = 8'd3;
    tick();
    check("t5_valid_gone", res_vld, 0);
    check("t5_idle", start_rdy, 1);
    tick();
    start_vld = 1'b0; ready = 1'b0;
    check("t5_clr", clr, 1);
    wait_valid(10);
    check("t5_result2", result, 3);
    accept();

`ifdef USADD_CTRL_ABORT_EN
    // 6: abort in run cycle 2 of L=8
    start(8);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_aborted", aborted, 1);
    check("t6_no_valid", res_vld, 0);
    check("t6_result_kept", result, 3);
    check("t6_idle", start_rdy, 1);
    tick();
    check("t6_pulse_end", aborted, 0);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      start_vld = $urandom_range(0, 1) == 1;
      len       = CNT_W'($urandom_range(0, 15));
      sadd      = $urandom_range(0, 1) == 1;
      ready     = $urandom_range(0, 2) != 0;
`ifdef USADD_CTRL_ABORT_EN
      abort     = ($urandom_range(0, 39) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
